// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one cache request in flight and queues returned words toward decode.
// Optional misaligned-redirect trap entries are enabled by defining IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] cpu_addr,
   output logic        cpu_req,
   input  logic [31:0] cpu_data,
   input  logic        cpu_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_fault,
   input  logic        if_ready
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t           state_reg;
   logic             cpu_req_reg;
   logic [31:0]      cpu_addr_reg;
   logic [31:0]      pc_reg;
   logic [31:0]      pc_next;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [31:0]      instr_mem [DEPTH];
   logic [31:0]      pc_mem    [DEPTH];

   logic accept;
   logic push;
   logic pop;
   logic trap;
   logic halt;
   logic halt_next;

`ifdef IFU_MISALIGN_TRAP_EN
   logic fault_mem [DEPTH];
   logic halt_reg;

   assign trap      = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign halt      = halt_reg;
   assign halt_next = redirect_valid ? trap : halt_reg;
   assign if_fault  = fault_mem[rd_ptr_reg];

   // A trapped redirect parks the unit until software redirects again.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         halt_reg <= 1'b0;
      end else begin
         halt_reg <= halt_next;
      end
   end
`else
   logic unused_low_bits;

   assign trap            = 1'b0;
   assign halt            = 1'b0;
   assign halt_next       = 1'b0;
   assign if_fault        = 1'b0;
   assign unused_low_bits = ^redirect_pc[1:0];
`endif

   assign cpu_req  = cpu_req_reg;
   assign cpu_addr = cpu_addr_reg;
   assign accept   = cpu_req_reg & cpu_ready;
   assign push     = accept & (state_reg == FETCH) & ~redirect_valid;
   assign if_valid = (count_reg != '0);
   assign pop      = if_valid & if_ready;
   assign if_instr = instr_mem[rd_ptr_reg];
   assign if_pc    = pc_mem[rd_ptr_reg];

   always_comb begin
      pc_next = pc_reg;
      if (redirect_valid) begin
         pc_next = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         pc_next = pc_reg + 32'd4;
      end
   end

   // A redirect flushes everything; a pop in the same cycle is simply absorbed.
   always_comb begin
      count_next = count_reg;
      if (redirect_valid) begin
         count_next = CNT_W'(trap);
      end else begin
         count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg    <= IDLE;
         cpu_req_reg  <= 1'b0;
         cpu_addr_reg <= RESET_PC;
      end else begin
         cpu_addr_reg <= pc_next;
         unique case (state_reg)
            IDLE: begin
               if (!redirect_valid && !halt && (count_reg < DEPTH_C)) begin
                  state_reg   <= FETCH;
                  cpu_req_reg <= 1'b1;
               end
            end
            FETCH: begin
               if (redirect_valid && !accept) begin
                  state_reg    <= DRAIN;
                  cpu_addr_reg <= cpu_addr_reg;
               end else if (accept && (halt_next || (count_next == DEPTH_C))) begin
                  state_reg   <= IDLE;
                  cpu_req_reg <= 1'b0;
               end
            end
            DRAIN: begin
               // The stale request keeps its address until the cache answers.
               if (!accept) begin
                  cpu_addr_reg <= cpu_addr_reg;
               end else if (halt_next || (count_next == DEPTH_C)) begin
                  state_reg   <= IDLE;
                  cpu_req_reg <= 1'b0;
               end else begin
                  state_reg <= FETCH;
               end
            end
            default: begin
               state_reg   <= IDLE;
               cpu_req_reg <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_mem[i] <= 1'b0;
`endif
         end
      end else if (redirect_valid) begin
         count_reg  <= count_next;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= PTR_W'(trap);
`ifdef IFU_MISALIGN_TRAP_EN
         if (trap) begin
            instr_mem[0] <= '0;
            pc_mem[0]    <= redirect_pc;
            fault_mem[0] <= 1'b1;
         end
`endif
      end else begin
         count_reg <= count_next;
         if (push) begin
            instr_mem[wr_ptr_reg] <= cpu_data;
            pc_mem[wr_ptr_reg]    <= pc_reg;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_mem[wr_ptr_reg] <= 1'b0;
`endif
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage sitting directly upstream of the instruction cache controller. Owns the program counter and issues one instruction request at a time on the cache's CPU-side request/ready interface. Buffers returned words with their PCs in a small queue toward decode, and handles control-flow redirects. A redirect never aborts an in-flight cache fill; the unit drains it and discards the stale word.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 4: instruction queue entries. Must be a power of 2 and ≥2.
- HCLK  in  1  sole clock; all state updates on rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- redirect_valid  in  1  control-flow redirect request; one-cycle pulse.
- redirect_pc  in  32  redirect target.
- cpu_addr  out  32  fetch address to the cache. Word-aligned; equals the internal PC register.
- cpu_req  out  1  fetch request to the cache.
- cpu_data  in  32  instruction word from the cache; valid when cpu_ready=1.
- cpu_ready  in  1  cache response strobe.
- if_valid  out  1  queue head valid toward decode.
- if_instr  out  32  queue head instruction.
- if_pc  out  32  queue head PC.
- if_fault  out  1  queue head is a misaligned-target fault entry. Tied 0 without the macro.
- if_ready  in  1  decode accepts the head this cycle.

## Operation
- Outstanding requests: at most one at a time.
- Request hold: while cpu_req=1, cpu_addr and cpu_req are held stable until the response is accepted. Response accepted = cpu_req & cpu_ready.
- Queue: FIFO with registered count 0..DEPTH.
  - Push on accepted response in FETCH: {pc, cpu_data, fault=0}.
  - Pop on if_valid & if_ready.
  - Wrap-around via log2(DEPTH)-bit pointers.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: cpu_req=0. Go to FETCH when count<DEPTH and no redirect this cycle. A redirect in IDLE loads pc and stays IDLE for one cycle.
  - FETCH: cpu_req=1. On accept: push, pc<=pc+4 (mod 2^32). Next state is FETCH if count_next<DEPTH, else IDLE.
  - DRAIN: cpu_req=1 with the old address. On accept: drop data, go to FETCH (or IDLE if the queue is full).
- Free-slot guarantee: a request is only issued when count<DEPTH, so a push never finds the queue full.
- Redirect, flush side: flushes the queue (count<=0) and loads pc<=redirect_pc with bits [1:0] cleared. A head popped in the same cycle counts as consumed.
- Redirect, in FETCH without an accept that cycle: go to DRAIN.
- Redirect, in FETCH with an accept that cycle: discard the response (no push, no pc+4) and go to FETCH.
- Redirect in DRAIN: update pc target and stay in DRAIN.
- Push and pop in the same cycle: count unchanged.

## Timing
- Reset values: cpu_req=0, cpu_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_fault=0. FSM=IDLE, count=0, pointers=0, queue storage cleared.
- First request: cpu_req rises in cycle 1 after reset deasserts (IDLE→FETCH).
- Response to decode: the word is visible on if_valid one cycle after acceptance; no bypass.
- Back-to-back: FETCH→FETCH issues the next address in the cycle after acceptance.
- Reset mid-operation: abandons any outstanding request immediately.

## Configuration
- IFU_MISALIGN_TRAP_EN defined:
  - Redirect with redirect_pc[1:0]≠0 flushes the queue and pushes one entry {pc=redirect_pc, instr=0, fault=1} on the next cycle. An in-flight request is still drained first.
  - The FSM then stays in IDLE, issuing nothing, until the next redirect.
- IFU_MISALIGN_TRAP_EN undefined: low bits are silently cleared and if_fault is constant 0.

## Test plan
- Reset sequence: reset, release, cache returns 0x00000013 after 2 cycles → cpu_addr=0x0; then if_valid=1, if_pc=0x0, if_instr=0x00000013; next cpu_addr=0x4.
- Queue full: if_ready=0, cache always ready → exactly 4 pushes (PCs 0x0–0xC); cpu_req=0 after the 4th accept. One pop → cpu_req reasserts with cpu_addr=0x10.
- Redirect during fill: cpu_req held at 0x20 for 5 cycles, redirect to 0x100 on cycle 2 → cpu_addr stays 0x20 until accept; that word is dropped; next request is 0x100; queue empty meanwhile.
- Redirect coincident with accept: redirect to 0x200 in the same cycle as an accept for 0x8 → no push of 0x8; next cpu_addr=0x200.
- Pointer wrap: 12 pushes/pops with if_ready toggling → PCs emerge in order 0x0..0x2C with no loss or duplication.
- Misaligned target (macro on): redirect to 0x102 → single entry with if_fault=1 and if_pc=0x102; no further cpu_req until the next redirect. With the macro off: fetch resumes at 0x100.
